// File: rtl/fin_butee_pkg.sv
// Shared definitions for the end-stop input PIO: register addresses and edge selection codes.
package fin_butee_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } addr_e;

  typedef enum int unsigned {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_e;

endpackage

// File: rtl/fin_butee_debounce.sv
// One end-stop bit: 2-FF synchroniser followed by a counter debounce producing the accepted level.
module fin_butee_debounce #(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic stable_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Count only while the synced input disagrees; any agreement restarts the window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/fin_butee_pio_in.sv
// Avalon-MM input PIO for the actuator end-stop switches: debounced data, sticky edge capture, masked IRQ.
module fin_butee_pio_in
  import fin_butee_pkg::*;
#(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned EDGE_TYPE  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edge_hit, clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    fin_butee_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .din_i    (in_port[g]),
      .stable_o (stable[g])
    );
  end

  if (WIDTH < 32) begin : g_wd_hi
    logic wdata_hi_unused;
    assign wdata_hi_unused = ^writedata[31:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
      edgecap_q    <= '0;
      irqmask_q    <= '0;
      readdata_q   <= '0;
    end else begin
      stable_dly_q <= stable;
      edgecap_q    <= edgecap_d;
      irqmask_q    <= irqmask_d;
      readdata_q   <= readdata_d;
    end
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    if (EDGE_TYPE == EDGE_RISE)      edge_hit = stable & ~stable_dly_q;
    else if (EDGE_TYPE == EDGE_FALL) edge_hit = ~stable & stable_dly_q;
    else                             edge_hit = stable ^ stable_dly_q;

    irqmask_d = irqmask_q;
    if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];

    clr = '0;
    if (wr_en && address == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
    // OR the new edge after clearing so a coincident edge is never dropped.
    edgecap_d = (edgecap_q & ~clr) | edge_hit;

    readdata_d = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
        ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
        ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
        default:      readdata_d = '0;
      endcase
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_fin_butee_pio_in.sv
// Bench for fin_butee_pio_in: directed end-stop scenarios plus random traffic against a reference model.
module tb_fin_butee_pio_in;

  localparam int unsigned DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  in_port = 2'b00;
  logic        irq;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic        chk_on = 1'b0;

  fin_butee_pio_in #(.WIDTH(2), .DEB_CYCLES(DEB), .EDGE_TYPE(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: synced value is the pin seen two clocks ago; a bit is accepted once it
  // has disagreed with the accepted level for DEB consecutive clocks.
  logic [1:0]  rawq[$] = '{2'b00, 2'b00};
  logic [1:0]  m_stable = '0, m_chg = '0, m_ec = '0, m_mask = '0;
  logic [31:0] m_rd = '0;
  int unsigned m_run[2] = '{0, 0};
  logic [1:0]  s, ns, clr;
  logic        m_irq;

  assign m_irq = |(m_ec & m_mask);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_stable <= '0;
      m_chg    <= '0;
      m_ec     <= '0;
      m_mask   <= '0;
      m_rd     <= '0;
      m_run    <= '{0, 0};
      rawq      = '{2'b00, 2'b00};
    end else begin
      s = rawq.pop_front();
      rawq.push_back(in_port);
      ns = m_stable;
      for (int i = 0; i < 2; i++) begin
        if (s[i] != m_stable[i]) begin
          if (m_run[i] + 1 == DEB) begin
            ns[i] = s[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
      if (!chipselect)        m_rd <= '0;
      else if (address == 0)  m_rd <= {30'd0, m_stable};
      else if (address == 2)  m_rd <= {30'd0, m_mask};
      else if (address == 3)  m_rd <= {30'd0, m_ec};
      else                    m_rd <= '0;
      clr = (chipselect && !write_n && address == 3) ? writedata[1:0] : 2'b00;
      if (chipselect && !write_n && address == 2) m_mask <= writedata[1:0];
      m_ec     <= (m_ec & ~clr) | m_chg;
      m_chg    <= ns ^ m_stable;
      m_stable <= ns;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("rdata_model", readdata, m_rd);
      check_eq("irq_model", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
    check_eq(tag, readdata, exp);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    check_eq("reset_rdata", readdata, 32'd0);
    check_eq("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd_chk("rst_data", 2'd0, 32'd0);
    rd_chk("rst_mask", 2'd2, 32'd0);
    rd_chk("rst_ecap", 2'd3, 32'd0);

    // Accepted rising edge on bit0, then back low, then a too-short pulse.
    @(negedge clk) in_port[0] = 1'b1;
    idle(12);
    rd_chk("deb_data1", 2'd0, 32'd1);
    rd_chk("deb_ecap1", 2'd3, 32'd1);
    wr(2'd3, 32'd1);
    @(negedge clk) in_port[0] = 1'b0;
    idle(12);
    wr(2'd3, 32'd1);
    @(negedge clk) in_port[0] = 1'b1;
    idle(3);
    in_port[0] = 1'b0;
    idle(12);
    rd_chk("pulse_data", 2'd0, 32'd0);
    rd_chk("pulse_ecap", 2'd3, 32'd0);

    // Bouncing bit1 settles high: one accept, one edge.
    @(negedge clk) in_port[1] = 1'b1;
    idle(2);
    in_port[1] = 1'b0;
    idle(2);
    in_port[1] = 1'b1;
    idle(12);
    rd_chk("bounce_ecap", 2'd3, 32'h2);
    rd_chk("bounce_data", 2'd0, 32'h2);

    // Masked interrupt behaviour.
    wr(2'd2, 32'd1);
    wr(2'd3, 32'd3);
    @(negedge clk) in_port[1] = 1'b0;
    idle(12);
    check_eq("irq_masked", {31'd0, irq}, 32'd0);
    @(negedge clk) in_port[0] = 1'b1;
    idle(12);
    check_eq("irq_set", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'd1);
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("irq_ecap", 2'd3, 32'h2);

    // Clear of bit0 lands on the same clock as a fresh accepted edge on bit0.
    @(negedge clk) in_port[0] = 1'b0;
    idle(12);
    @(negedge clk) in_port[0] = 1'b1;
    idle(5);
    wr(2'd3, 32'd1);
    check_eq("coll_irq", {31'd0, irq}, 32'd1);
    rd_chk("coll_ecap", 2'd3, 32'h3);

    // Writes to read-only locations have no effect.
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_chk("ro_data", 2'd0, 32'h1);
    rd_chk("ro_rsvd", 2'd1, 32'h0);
    rd_chk("ro_mask", 2'd2, 32'h1);

    // Random traffic, with one reset in the middle.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (n == 1000) begin
        reset_n = 1'b0;
        chipselect = 1'b0; write_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, 1)] ^= 1'b1;
      case ($urandom_range(0, 7))
        0: begin
          chipselect = 1'b1; write_n = 1'b0;
          address = 2'($urandom_range(0, 3)); writedata = $urandom;
        end
        1, 2, 3: begin
          chipselect = 1'b1; write_n = 1'b1;
          address = 2'($urandom_range(0, 3)); writedata = $urandom;
        end
        default: begin
          chipselect = 1'b0; write_n = 1'b1;
        end
      endcase
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
